alarm_dismiss: RTL and testbench

Responder side of the alarm handshake in the math alarm clock. While `alarm` is high, the block presents a randomly generated arithmetic problem and collects a two-digit answer from push keys. It asserts `alarm_off` only after a correct answer and holds it until the alarm side drops `alarm`. Operand, operator and answer-digit outputs drive the seven-segment display mux.

---
 rtl/alarm_dismiss_pkg.sv | 24 ++
 rtl/alarm_dismiss_lfsr8.sv | 31 +++
 rtl/alarm_dismiss.sv | 167 ++++++++++++++++
 tb/tb_alarm_dismiss.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_dismiss_pkg.sv
// Shared definitions for the math-alarm dismiss responder: state encoding,
// LFSR constants, widths and the operand fold helper.
package alarm_dismiss_pkg;

    localparam int DIGIT_W = 4;
    localparam int ANS_W   = 7;

    // Feedback taps at bits 7, 5, 4 and 3 of the Fibonacci register.
    localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        CHECK,
        DISMISS
    } state_e;

    // Maps a raw nibble onto a decimal digit 0..9.
    function automatic logic [DIGIT_W-1:0] fold(input logic [3:0] n);
        return (n > 4'd9) ? n - 4'd6 : n;
    endfunction

endpackage

// File: rtl/alarm_dismiss_lfsr8.sv
// 8-bit Fibonacci LFSR shifting left every cycle; a zero seed is replaced by
// 8'h01 so the register can never lock up.
module lfsr8
    import alarm_dismiss_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] state
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/alarm_dismiss.sv
// alarm_dismiss: while alarm is high, presents a random arithmetic problem,
// collects a two-digit answer from push keys and raises alarm_off when correct.
module alarm_dismiss
    import alarm_dismiss_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alarm,
    input  logic               ans_tensKEY,
    input  logic               ans_onesKEY,
    input  logic               submitKEY,
    output logic [DIGIT_W-1:0] operand_a,
    output logic [DIGIT_W-1:0] operand_b,
    output logic               op_mul,
    output logic [DIGIT_W-1:0] ans_tens,
    output logic [DIGIT_W-1:0] ans_ones,
    output logic               active,
    output logic               alarm_off,
    output logic               wrong,
    output logic [2:0]         wrong_count
);

    localparam int K_TENS = 0;
    localparam int K_ONES = 1;
    localparam int K_SUB  = 2;

    function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
        return (d == DIGIT_W'(9)) ? '0 : d + DIGIT_W'(1);
    endfunction

    logic [7:0] lfsr;

    lfsr8 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    state_e             state_q, state_d;
    logic [2:0]         key_in, flag_q, flag_d, fire;
    logic [DIGIT_W-1:0] operand_a_q, operand_a_d, operand_b_q, operand_b_d;
    logic               op_mul_q, op_mul_d;
    logic [DIGIT_W-1:0] ans_tens_q, ans_tens_d, ans_ones_q, ans_ones_d;
    logic               active_q, active_d, alarm_off_q, alarm_off_d;
    logic               wrong_q, wrong_d;
    logic [2:0]         wrong_count_q, wrong_count_d;
    logic [ANS_W-1:0]   entry, expected;
    logic               latch;

    always_comb begin
        entry    = ANS_W'(ans_tens_q) * ANS_W'(10) + ANS_W'(ans_ones_q);
        expected = op_mul_q ? ANS_W'(operand_a_q) * ANS_W'(operand_b_q)
                            : ANS_W'(operand_a_q) + ANS_W'(operand_b_q);
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        operand_a_d   = operand_a_q;
        operand_b_d   = operand_b_q;
        op_mul_d      = op_mul_q;
        ans_tens_d    = ans_tens_q;
        ans_ones_d    = ans_ones_q;
        wrong_d       = 1'b0;
        wrong_count_d = wrong_count_q;
        latch         = 1'b0;

        // A key fires on the first low cycle after a press seen in PRESENT.
        key_in = {submitKEY, ans_onesKEY, ans_tensKEY};
        for (int i = 0; i < 3; i++) begin
            fire[i] = (state_q == PRESENT) && flag_q[i] && !key_in[i];
        end

        case (state_q)
            IDLE: begin
                if (alarm) begin
                    latch         = 1'b1;
                    wrong_count_d = '0;
                    state_d       = PRESENT;
                end
            end
            PRESENT: begin
                if (!alarm) begin
                    state_d = IDLE;
                end else begin
                    if (fire[K_TENS]) ans_tens_d = digit_inc(ans_tens_q);
                    if (fire[K_ONES]) ans_ones_d = digit_inc(ans_ones_q);
                    if (fire[K_SUB])  state_d    = CHECK;
                end
            end
            CHECK: begin
                if (!alarm) begin
                    state_d = IDLE;
                end else if (entry == expected) begin
                    state_d = DISMISS;
                end else begin
                    wrong_d       = 1'b1;
                    wrong_count_d = (wrong_count_q == 3'd7) ? 3'd7 : wrong_count_q + 3'd1;
                    latch         = 1'b1;
                    state_d       = PRESENT;
                end
            end
            DISMISS: begin
                if (!alarm) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            operand_a_d = fold(lfsr[3:0]);
            operand_b_d = fold(lfsr[7:4]);
            op_mul_d    = lfsr[7] ^ lfsr[0];
            ans_tens_d  = '0;
            ans_ones_d  = '0;
        end

        for (int i = 0; i < 3; i++) begin
            flag_d[i] = (state_d == PRESENT) && key_in[i];
        end

        active_d    = (state_d == PRESENT) || (state_d == CHECK);
        alarm_off_d = (state_d == DISMISS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            flag_q        <= '0;
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            op_mul_q      <= 1'b0;
            ans_tens_q    <= '0;
            ans_ones_q    <= '0;
            active_q      <= 1'b0;
            alarm_off_q   <= 1'b0;
            wrong_q       <= 1'b0;
            wrong_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flag_q        <= flag_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            op_mul_q      <= op_mul_d;
            ans_tens_q    <= ans_tens_d;
            ans_ones_q    <= ans_ones_d;
            active_q      <= active_d;
            alarm_off_q   <= alarm_off_d;
            wrong_q       <= wrong_d;
            wrong_count_q <= wrong_count_d;
        end
    end

    assign operand_a   = operand_a_q;
    assign operand_b   = operand_b_q;
    assign op_mul      = op_mul_q;
    assign ans_tens    = ans_tens_q;
    assign ans_ones    = ans_ones_q;
    assign active      = active_q;
    assign alarm_off   = alarm_off_q;
    assign wrong       = wrong_q;
    assign wrong_count = wrong_count_q;

endmodule

// File: tb/tb_alarm_dismiss.sv
// Self-checking bench for alarm_dismiss: an independent LFSR model picks the
// moment to raise alarm so known problems are latched; results go through a scoreboard.
module tb_alarm_dismiss;

    localparam logic [7:0] SEED = 8'hA5;

    logic       clock = 1'b0;
    logic       reset, alarm, ans_tensKEY, ans_onesKEY, submitKEY;
    logic [3:0] operand_a, operand_b, ans_tens, ans_ones;
    logic       op_mul, active, alarm_off, wrong;
    logic [2:0] wrong_count;

    alarm_dismiss #(.LFSR_SEED(SEED)) dut (
        .clock       (clock),
        .reset       (reset),
        .alarm       (alarm),
        .ans_tensKEY (ans_tensKEY),
        .ans_onesKEY (ans_onesKEY),
        .submitKEY   (submitKEY),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_mul      (op_mul),
        .ans_tens    (ans_tens),
        .ans_ones    (ans_ones),
        .active      (active),
        .alarm_off   (alarm_off),
        .wrong       (wrong),
        .wrong_count (wrong_count)
    );

    always #5 clock = ~clock;

    // Reference LFSR, stepped on the same edges as the design.
    logic [7:0] m_l;
    always @(posedge clock) begin
        m_l <= reset ? SEED : {m_l[6:0], m_l[7] ^ m_l[5] ^ m_l[4] ^ m_l[3]};
    end

    int n_pulse = 0;
    always @(negedge clock) if (wrong === 1'b1) n_pulse++;

    typedef struct packed {
        logic       dismiss;
        logic [2:0] wc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int tens_n;
        int ones_n;
        int exp_t;
        int exp_o;
    } dig_vec_t;
    dig_vec_t vecs[3];

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] cur_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] m_fold(input logic [3:0] n);
        if (n > 4'd9) return n - 4'd6;
        return n;
    endfunction

    function automatic logic [6:0] answer_of(input logic [7:0] l);
        logic [6:0] a, b;
        a = {3'b000, m_fold(l[3:0])};
        b = {3'b000, m_fold(l[7:4])};
        return (l[7] ^ l[0]) ? a * b : a + b;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // m[0]=tens, m[1]=ones, m[2]=submit
    task automatic drive(input logic [2:0] m);
        ans_tensKEY = m[0];
        ans_onesKEY = m[1];
        submitKEY   = m[2];
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        drive(m);
        repeat (hold) tick();
        drive(3'b000);
        tick();
    endtask

    task automatic enter(input int value);
        for (int i = 0; i < value / 10; i++) press(3'b001, 1);
        for (int i = 0; i < value % 10; i++) press(3'b010, 1);
    endtask

    task automatic check_problem(input string tag, input logic [7:0] l);
        check({tag, "_operand_a"}, operand_a, m_fold(l[3:0]));
        check({tag, "_operand_b"}, operand_b, m_fold(l[7:4]));
        check({tag, "_op_mul"}, op_mul, l[7] ^ l[0]);
        check({tag, "_digits"}, {ans_tens, ans_ones}, 8'h00);
    endtask

    task automatic start_problem(input logic [7:0] target);
        int i;
        i = 0;
        while (m_l !== target && i < 600) begin
            tick();
            i++;
        end
        if (m_l !== target) begin
            n_fail++;
            $display("FAIL wait_lfsr: model never reached %0h", target);
        end
        alarm = 1'b1;
        tick();
        cur_l = target;
        check("start_active", active, 1);
        check("start_wrong_count", wrong_count, 0);
        check_problem("start", target);
    endtask

    // Submits with optional extra keys released in the same cycle.
    task automatic submit(input logic [2:0] extra, input logic exp_dismiss, input logic [2:0] exp_wc);
        sb_t        e;
        logic [7:0] next_l;
        sb.push_back('{dismiss: exp_dismiss, wc: exp_wc});
        drive(3'b100 | extra);
        tick();
        drive(3'b000);
        tick();
        check("check_active", active, 1);
        check("check_no_early_off", alarm_off, 0);
        next_l = m_l;
        tick();
        e = sb.pop_front();
        check("result_alarm_off", alarm_off, e.dismiss);
        check("result_wrong", wrong, !e.dismiss);
        check("result_wrong_count", wrong_count, e.wc);
        if (!e.dismiss) begin
            check_problem("relatch", next_l);
            cur_l = next_l;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] lat;
        vecs[0] = '{6, 0, 6, 0};
        vecs[1] = '{0, 10, 6, 0};
        vecs[2] = '{10, 2, 6, 2};

        reset = 1'b1;
        alarm = 1'b0;
        drive(3'b000);
        #1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset_outputs",
              {operand_a, operand_b, op_mul, ans_tens, ans_ones, active, alarm_off, wrong, wrong_count}, 0);

        // 3+4, answered with seven ones presses
        start_problem(8'hA3);
        enter(7);
        check("ones_after_7", ans_ones, 7);
        submit(3'b000, 1'b1, 3'd0);
        alarm = 1'b0;
        tick();
        check("drop_alarm_off", alarm_off, 0);
        check("drop_active", active, 0);

        // 9*7 with table-driven digit entry, wrap-around and a long hold
        start_problem(8'h79);
        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].tens_n; i++) press(3'b001, 1);
            for (int i = 0; i < vecs[v].ones_n; i++) press(3'b010, 1);
            check($sformatf("vec%0d_tens", v), ans_tens, vecs[v].exp_t);
            check($sformatf("vec%0d_ones", v), ans_ones, vecs[v].exp_o);
        end
        drive(3'b010);
        repeat (50) tick();
        check("hold_no_increment", ans_ones, 2);
        drive(3'b000);
        tick();
        check("hold_one_increment", ans_ones, 3);
        submit(3'b000, 1'b1, 3'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 20 == 19) check("alarm_off_held", alarm_off, 1);
        end
        alarm = 1'b0;
        tick();
        check("dismiss_release_off", alarm_off, 0);
        check("dismiss_release_active", active, 0);

        // Eight wrong answers: count saturates, a new problem each time
        start_problem(8'h99);
        n_pulse = 0;
        for (int i = 0; i < 8; i++) begin
            if (answer_of(cur_l) == 7'd0) press(3'b010, 1);
            submit(3'b000, 1'b0, (i + 1 > 7) ? 3'd7 : 3'(i + 1));
            tick();
            check("wrong_one_cycle", wrong, 0);
        end
        check("wrong_pulse_total", n_pulse, 8);
        alarm = 1'b0;
        tick();

        // 9+9: tens/ones together, then ones released with submit
        start_problem(8'h99);
        press(3'b011, 1);
        check("both_digits", {ans_tens, ans_ones}, 8'h11);
        for (int i = 0; i < 6; i++) press(3'b010, 1);
        submit(3'b010, 1'b1, 3'd0);
        check("same_cycle_ones", ans_ones, 8);
        alarm = 1'b0;
        tick();

        // alarm dropping together with a submit release
        start_problem(8'hA3);
        enter(7);
        drive(3'b100);
        tick();
        drive(3'b000);
        alarm = 1'b0;
        tick();
        check("drop_with_submit_active", active, 0);
        tick();
        check("drop_with_submit_off", alarm_off, 0);

        // reset in PRESENT with alarm held high
        alarm = 1'b1;
        tick();
        press(3'b010, 1);
        reset = 1'b1;
        tick();
        check("midreset_outputs",
              {operand_a, operand_b, op_mul, ans_tens, ans_ones, active, alarm_off, wrong, wrong_count}, 0);
        reset = 1'b0;
        lat = m_l;
        tick();
        check("midreset_active", active, 1);
        check_problem("midreset", lat);

        // correct answer but alarm dropped while in CHECK
        enter(int'(answer_of(lat)));
        drive(3'b100);
        tick();
        drive(3'b000);
        tick();
        check("drop_check_active", active, 1);
        alarm = 1'b0;
        tick();
        check("drop_check_idle", active, 0);
        check("drop_check_off", alarm_off, 0);
        tick();
        check("drop_check_off_later", alarm_off, 0);
        check("drop_check_wrong", wrong, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
